ad5683_spi_rx: RTL and testbench
================================

// Module: ad5683_spi_rx
// PURPOSE
//  SPI slave that decodes AD5683-format 24-bit write frames (SYNC_N/SCLK/MOSI) into a DAC register model.
//  Serves as the on-chip loopback target and bench model for the DAC write link.
//  Also a drop-in receiver where the FPGA emulates an AD568x.
//  All SPI pins are asynchronous to clk; they are oversampled and decoded in the clk domain.
// PARAMETERS
//  DAC_BITS    16     resolution of dac_code (16/14/12); code = dac_reg[15 -: DAC_BITS]
//  RESET_CODE  16'h0  value loaded into input_reg/dac_reg on rst and on software reset
// PORTS
//  clk          in   1          system clock; sclk high and low phases must each be >= 3 clk periods
//  rst          in   1          synchronous, active-high reset
//  sclk         in   1          SPI clock (async); MOSI sampled on falling edge
//  mosi         in   1          SPI data, MSB first (async)
//  sync_n       in   1          frame select, active low (async)
//  ldac_n       in   1          hardware load (async); falling edge copies input_reg -> dac_reg
//  input_reg    out  16         AD5683 input register
//  dac_reg      out  16         AD5683 DAC register
//  dac_code     out  DAC_BITS   dac_reg[15 -: DAC_BITS]
//  ctrl_reg     out  5          control {PD[1:0],REF,GAIN,DCEN} = frame bits 18:14
//  cmd          out  4          command of last valid frame
//  frame_valid  out  1          1-clk pulse: 24-bit frame accepted
//  frame_err    out  1          1-clk pulse: frame closed with < 24 bits, discarded
// BEHAVIOUR
//  Reset: input_reg = dac_reg = RESET_CODE; ctrl_reg = 0; cmd = 0; pulses = 0; FSM = WAIT_HI.
//  Sync: sclk, mosi, sync_n, ldac_n each pass a 2-FF synchronizer plus a prev register for edge detect.
//  FSM:
//   WAIT_HI: go IDLE when sync_s = 1. Prevents a frame already in progress at reset release being taken.
//   IDLE: sync_s falling -> SHIFT, bitcnt = 0, shreg = 0.
//   SHIFT:
//    - sclk_s fall and bitcnt < 24: shreg <= {shreg[22:0], mosi_s}, bitcnt++.
//    - Bits beyond 24 are ignored; bitcnt saturates at 24.
//    - sync_s rise -> DECODE.
//    - If sync_s rise and sclk_s fall are detected in the same cycle, sync wins and the bit is dropped.
//   DECODE (1 cycle) -> IDLE. Frame fields: shreg[23:20] = C, shreg[19:4] = D, shreg[3:0] ignored.
//    - bitcnt < 24: frame_err = 1; no register changes.
//    - bitcnt == 24: frame_valid = 1; cmd <= C; act on C as below.
//  Commands:
//    0000  NOP
//    0001  input_reg <= D
//    0010  dac_reg <= input_reg
//    0011  input_reg <= D; dac_reg <= D
//    0100  control write:
//           - if D[15] (frame bit 19) = 1: software reset. input/dac = RESET_CODE, ctrl_reg = 0 (bit self-clears).
//           - else ctrl_reg <= D[14:10].
//    other: valid NOP (frame_valid = 1, cmd updated).
//  Latency: registers, cmd and pulses update 3 clk edges after the first edge that samples sync_n high.
//  LDAC:
//   - ldac_s falling -> dac_reg <= input_reg next edge.
//   - Same cycle as a DECODE that writes dac_reg or input_reg: DECODE result wins; LDAC copy dropped.
//  sync_n high -> low -> high with no sclk edges gives frame_err (0 bits).
//  rst mid-frame: immediate reset values, FSM = WAIT_HI, partial frame discarded.
//  Outputs change only on clk edges; ctrl_reg/input_reg/dac_reg hold between frames.
// TESTING
//  1. rst, then frame 0x3ABCD0 -> input_reg = dac_reg = 16'hABCD, cmd = 3, one frame_valid pulse.
//  2. Frame 0x112340 -> input_reg = 1234, dac_reg unchanged.
//     Then pulse ldac_n low for 4 clk -> dac_reg = 1234.
//     Repeat with frame 0x2xxxxx -> dac_reg = input_reg.
//  3. Frame 0x355550 with sync_n raised after 20 sclk falls -> frame_err pulse; all regs unchanged; next full frame accepted.
//  4. 30-bit burst starting 0x3F00F0... -> first 24 bits used, dac_reg = F00F, no frame_err.
//  5. Frame 0x4xxxxx with D = 0x6C00 -> ctrl_reg = 5'b11011.
//     Then D = 0x8000 -> input/dac = RESET_CODE, ctrl_reg = 0.
//  6. Assert rst after 10 bits with sync_n still low -> regs reset; remaining bits ignored until sync_n high; next frame decodes.
//     Also random frames at sclk half-period 8 clk vs scoreboard.

Source files
------------

// File: rtl/ad5683_spi_rx.sv
// AD5683-format SPI slave: oversamples SYNC_N/SCLK/MOSI/LDAC_N in the clk domain
// and decodes 24-bit write frames into an input/DAC/control register model.
module ad5683_spi_rx #(
  parameter int          DAC_BITS   = 16,
  parameter logic [15:0] RESET_CODE = 16'h0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sclk,
  input  logic                mosi,
  input  logic                sync_n,
  input  logic                ldac_n,
  output logic [15:0]         input_reg,
  output logic [15:0]         dac_reg,
  output logic [DAC_BITS-1:0] dac_code,
  output logic [4:0]          ctrl_reg,
  output logic [3:0]          cmd,
  output logic                frame_valid,
  output logic                frame_err,
  output logic [1:0]          dbg_state
);

  typedef enum logic [1:0] {
    S_WAIT_HI = 2'd0,
    S_IDLE    = 2'd1,
    S_SHIFT   = 2'd2,
    S_DECODE  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  sclk_sync_q, mosi_sync_q, sync_sync_q, ldac_sync_q;
  logic        sclk_prev_q, sync_prev_q, ldac_prev_q;
  logic [19:0] shreg_q, shreg_d;
  logic [4:0]  bitcnt_q, bitcnt_d;
  logic [15:0] input_q, input_d, dac_q, dac_d;
  logic [4:0]  ctrl_q, ctrl_d;
  logic [3:0]  cmd_q, cmd_d;
  logic        valid_q, valid_d, err_q, err_d;

  logic sclk_s, mosi_s, sync_s, ldac_s;
  logic sclk_fall, sync_fall, sync_rise, ldac_fall;

  // SYNC_N resets low so a frame still open at reset release is never seen as a start.
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sync_q <= 2'b00;
      mosi_sync_q <= 2'b00;
      sync_sync_q <= 2'b00;
      ldac_sync_q <= 2'b11;
      sclk_prev_q <= 1'b0;
      sync_prev_q <= 1'b0;
      ldac_prev_q <= 1'b1;
    end else begin
      sclk_sync_q <= {sclk_sync_q[0], sclk};
      mosi_sync_q <= {mosi_sync_q[0], mosi};
      sync_sync_q <= {sync_sync_q[0], sync_n};
      ldac_sync_q <= {ldac_sync_q[0], ldac_n};
      sclk_prev_q <= sclk_sync_q[1];
      sync_prev_q <= sync_sync_q[1];
      ldac_prev_q <= ldac_sync_q[1];
    end
  end

  assign sclk_s    = sclk_sync_q[1];
  assign mosi_s    = mosi_sync_q[1];
  assign sync_s    = sync_sync_q[1];
  assign ldac_s    = ldac_sync_q[1];
  assign sclk_fall = ~sclk_s & sclk_prev_q;
  assign sync_fall = ~sync_s & sync_prev_q;
  assign sync_rise = sync_s & ~sync_prev_q;
  assign ldac_fall = ~ldac_s & ldac_prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_WAIT_HI;
      shreg_q  <= '0;
      bitcnt_q <= '0;
      input_q  <= RESET_CODE;
      dac_q    <= RESET_CODE;
      ctrl_q   <= '0;
      cmd_q    <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      bitcnt_q <= bitcnt_d;
      input_q  <= input_d;
      dac_q    <= dac_d;
      ctrl_q   <= ctrl_d;
      cmd_q    <= cmd_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_WAIT_HI: if (sync_s)    state_d = S_IDLE;
      S_IDLE:    if (sync_fall) state_d = S_SHIFT;
      S_SHIFT:   if (sync_rise) state_d = S_DECODE;
      S_DECODE:                 state_d = S_IDLE;
      default:                  state_d = S_WAIT_HI;
    endcase
  end

  logic [3:0]  f_cmd;
  logic [15:0] f_data;
  logic        dec_writes;

  assign f_cmd  = shreg_q[19:16];
  assign f_data = shreg_q[15:0];

  always_comb begin
    shreg_d    = shreg_q;
    bitcnt_d   = bitcnt_q;
    input_d    = input_q;
    dac_d      = dac_q;
    ctrl_d     = ctrl_q;
    cmd_d      = cmd_q;
    valid_d    = 1'b0;
    err_d      = 1'b0;
    dec_writes = 1'b0;

    // Only the first 20 bits (command + data) are kept; the 4 trailing bits are just counted.
    if (state_q == S_IDLE && sync_fall) begin
      shreg_d  = '0;
      bitcnt_d = '0;
    end else if (state_q == S_SHIFT && !sync_rise && sclk_fall && bitcnt_q < 5'd24) begin
      if (bitcnt_q < 5'd20) shreg_d = {shreg_q[18:0], mosi_s};
      bitcnt_d = bitcnt_q + 5'd1;
    end

    if (state_q == S_DECODE) begin
      if (bitcnt_q == 5'd24) begin
        valid_d = 1'b1;
        cmd_d   = f_cmd;
        case (f_cmd)
          4'b0001: begin
            input_d    = f_data;
            dec_writes = 1'b1;
          end
          4'b0010: begin
            dac_d      = input_q;
            dec_writes = 1'b1;
          end
          4'b0011: begin
            input_d    = f_data;
            dac_d      = f_data;
            dec_writes = 1'b1;
          end
          4'b0100: begin
            if (f_data[15]) begin
              input_d    = RESET_CODE;
              dac_d      = RESET_CODE;
              ctrl_d     = '0;
              dec_writes = 1'b1;
            end else begin
              ctrl_d = f_data[14:10];
            end
          end
          default: ;
        endcase
      end else begin
        err_d = 1'b1;
      end
    end

    if (ldac_fall && !dec_writes) dac_d = input_q;
  end

  assign input_reg   = input_q;
  assign dac_reg     = dac_q;
  assign dac_code    = dac_q[15 -: DAC_BITS];
  assign ctrl_reg    = ctrl_q;
  assign cmd         = cmd_q;
  assign frame_valid = valid_q;
  assign frame_err   = err_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_ad5683_spi_rx.sv
// Bench for ad5683_spi_rx: directed AD5683 frames plus random frames, checked every
// cycle against a frame-level register model of the DAC.
module tb_ad5683_spi_rx;

  localparam int          DAC_BITS   = 12;
  localparam logic [15:0] RESET_CODE = 16'h5A5A;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic sclk = 1'b0, mosi = 1'b0, sync_n = 1'b1, ldac_n = 1'b1;
  logic [15:0]         input_reg, dac_reg;
  logic [DAC_BITS-1:0] dac_code;
  logic [4:0]          ctrl_reg;
  logic [3:0]          cmd;
  logic                frame_valid, frame_err;
  logic [1:0]          dbg_state;

  ad5683_spi_rx #(.DAC_BITS(DAC_BITS), .RESET_CODE(RESET_CODE)) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .mosi(mosi), .sync_n(sync_n), .ldac_n(ldac_n),
    .input_reg(input_reg), .dac_reg(dac_reg), .dac_code(dac_code), .ctrl_reg(ctrl_reg),
    .cmd(cmd), .frame_valid(frame_valid), .frame_err(frame_err), .dbg_state(dbg_state)
  );

  // reference model state
  logic [15:0] m_in, m_dac;
  logic [4:0]  m_ctrl;
  logic [3:0]  m_cmd;
  logic        m_valid = 1'b0, m_err = 1'b0;
  logic        live = 1'b0;
  logic [1:0]  exp_q[$];

  int n_checks = 0;
  int n_pass   = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endfunction

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) tick();
  endtask

  task automatic send_bits(input logic [31:0] word, input int nbits, input int half);
    for (int i = 0; i < nbits; i++) begin
      sclk = 1'b1;
      mosi = word[31-i];
      wait_cycles(half);
      sclk = 1'b0;
      wait_cycles(half);
    end
  endtask

  // Frame result appears on the 4th edge after sync_n is raised.
  task automatic model_frame(input logic [31:0] word, input int nbits);
    logic [3:0]  c;
    logic [15:0] d;
    c = word[31:28];
    d = word[27:12];
    repeat (4) @(posedge clk);
    if (nbits < 24) begin
      m_err = 1'b1;
      exp_q.push_back(2'b01);
    end else begin
      m_valid = 1'b1;
      m_cmd   = c;
      exp_q.push_back(2'b10);
      case (c)
        4'd1: m_in = d;
        4'd2: m_dac = m_in;
        4'd3: begin m_in = d; m_dac = d; end
        4'd4: begin
          if (d[15]) begin
            m_in = RESET_CODE; m_dac = RESET_CODE; m_ctrl = 5'd0;
          end else begin
            m_ctrl = d[14:10];
          end
        end
        default: ;
      endcase
    end
    @(posedge clk);
    m_valid = 1'b0;
    m_err   = 1'b0;
    #1;
  endtask

  task automatic send_frame(input logic [31:0] word, input int nbits, input int half);
    sync_n = 1'b0;
    wait_cycles(half);
    send_bits(word, nbits, half);
    sync_n = 1'b1;
    model_frame(word, nbits);
    wait_cycles(2);
  endtask

  task automatic pulse_ldac(input int n);
    ldac_n = 1'b0;
    repeat (3) @(posedge clk);
    m_dac = m_in;
    #1;
    wait_cycles(n - 3);
    ldac_n = 1'b1;
    wait_cycles(3);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    m_in = RESET_CODE; m_dac = RESET_CODE; m_ctrl = 5'd0; m_cmd = 4'd0;
    m_valid = 1'b0; m_err = 1'b0;
    live = 1'b1;
    #1;
    wait_cycles(2);
    rst = 1'b0;
    wait_cycles(2);
  endtask

  // scoreboard: per-cycle compare against the model, pulses against the event queue
  always @(negedge clk) begin
    if (live) begin
      check("input_reg", input_reg, m_in);
      check("dac_reg", dac_reg, m_dac);
      check("dac_code", dac_code, m_dac[15 -: DAC_BITS]);
      check("ctrl_reg", ctrl_reg, m_ctrl);
      check("cmd", cmd, m_cmd);
      check("frame_valid", frame_valid, m_valid);
      check("frame_err", frame_err, m_err);
      if (frame_valid | frame_err)
        check("pulse_order", {frame_valid, frame_err}, (exp_q.size() > 0) ? exp_q.pop_front() : 2'b00);
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]  c;
    logic [15:0] d;
    logic [31:0] word;
    int          nbits, sel;

    do_reset();
    check("rst_input", input_reg, 16'h5A5A);
    check("rst_ctrl", ctrl_reg, 5'd0);

    send_frame({24'h3ABCD0, 8'h00}, 24, 4);
    check("t1_input", input_reg, 16'hABCD);
    check("t1_dac", dac_reg, 16'hABCD);
    check("t1_code", dac_code, 12'hABC);
    check("t1_cmd", cmd, 4'd3);

    send_frame({24'h112340, 8'h00}, 24, 4);
    check("t2_input", input_reg, 16'h1234);
    check("t2_dac_hold", dac_reg, 16'hABCD);
    pulse_ldac(4);
    check("t2_ldac", dac_reg, 16'h1234);
    send_frame({24'h156780, 8'h00}, 24, 3);
    send_frame({24'h2FFFF0, 8'h00}, 24, 3);
    check("t2_cmd2", dac_reg, 16'h5678);

    send_frame({24'h355550, 8'h00}, 20, 4);
    check("t3_short", input_reg, 16'h5678);
    send_frame({24'h311110, 8'h00}, 24, 4);
    check("t3_next", dac_reg, 16'h1111);

    send_frame(32'h3F00F0AB, 30, 4);
    check("t4_burst", dac_reg, 16'hF00F);
    check("t4_cmd", cmd, 4'd3);

    send_frame({24'h46C000, 8'h00}, 24, 4);
    check("t5_ctrl", ctrl_reg, 5'b11011);
    send_frame({24'h480000, 8'h00}, 24, 4);
    check("t5_swrst_in", input_reg, 16'h5A5A);
    check("t5_swrst_ctrl", ctrl_reg, 5'd0);

    send_frame(32'h0, 0, 4);
    check("t5_zero_bits", cmd, 4'd4);

    send_frame({24'h3C0DE0, 8'h00}, 24, 4);
    sync_n = 1'b0;
    wait_cycles(4);
    send_bits({24'h399990, 8'h00}, 10, 4);
    do_reset();
    send_bits({24'h399990, 8'h00} << 10, 14, 4);
    sync_n = 1'b1;
    wait_cycles(8);
    check("t6_after_rst", dac_reg, 16'h5A5A);
    send_frame({24'h324680, 8'h00}, 24, 4);
    check("t6_next", input_reg, 16'h2468);

    for (int k = 0; k < 40; k++) begin
      c    = 4'($urandom_range(0, 7));
      d    = 16'($urandom);
      word = {c, d, 4'($urandom), 8'($urandom)};
      sel  = $urandom_range(0, 9);
      if (sel == 7)      nbits = $urandom_range(0, 23);
      else if (sel == 8) nbits = $urandom_range(25, 32);
      else               nbits = 24;
      send_frame(word, nbits, 8);
      if ($urandom_range(0, 2) == 0) pulse_ldac($urandom_range(3, 6));
    end

    wait_cycles(4);
    check("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
